// File: rtl/angle_cmd_parser_if.sv
// Byte-stream in / angle-command out signal bundle for angle_cmd_parser.
// master = UART-receiver side driving bytes, slave = the parser.
interface angle_cmd_parser_if;
   logic       i_RX_DV;
   logic [7:0] i_RX_Byte;
   logic       o_Angle_DV;
   logic [7:0] o_Angle;
   logic       o_Error;

   modport master (
      output i_RX_DV, i_RX_Byte,
      input  o_Angle_DV, o_Angle, o_Error
   );

   modport slave (
      input  i_RX_DV, i_RX_Byte,
      output o_Angle_DV, o_Angle, o_Error
   );
endinterface

// File: rtl/angle_cmd_parser.sv
// ASCII angle command parser: 1-3 digits + CR/LF -> registered angle strobe or error strobe.
// Optional inter-byte timeout enabled by defining ANGLE_CMD_TIMEOUT_EN.
module angle_cmd_parser #(
   parameter int g_Max_Angle    = 180,
   parameter int g_Timeout_Clks = 10_000_000
) (
   input  logic                     i_Clk,
   input  logic                     i_Reset,
   angle_cmd_parser_if.slave        bus,
   output logic [1:0]               state_dbg
);
   // Handshake: a byte is consumed only in a cycle with i_RX_DV=1; there is no
   // backpressure. o_Angle_DV / o_Error are one-cycle strobes one clock after
   // the deciding byte and are never high together.

   typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DISCARD = 2'd2} state_t;

   localparam logic [9:0] max_angle = 10'(g_Max_Angle);

   state_t     state, state_d;
   logic [9:0] acc, acc_d;
   logic [1:0] cnt, cnt_d;
   logic       dv_d, err_d, load;
   logic       is_digit, is_term, timeout;
   logic [3:0] digit;
   logic [13:0] acc_x10;

   assign state_dbg = state;
   assign is_digit  = (bus.i_RX_Byte >= 8'h30) && (bus.i_RX_Byte <= 8'h39);
   assign is_term   = (bus.i_RX_Byte == 8'h0D) || (bus.i_RX_Byte == 8'h0A);
   assign digit     = bus.i_RX_Byte[3:0];
   assign acc_x10   = acc * 4'd10;

`ifdef ANGLE_CMD_TIMEOUT_EN
   localparam int tmo_w = $clog2(g_Timeout_Clks + 1);
   localparam logic [tmo_w-1:0] tmo_last = tmo_w'(g_Timeout_Clks - 1);
   logic [tmo_w-1:0] tmo_cnt;

   // Fires on the g_Timeout_Clks-th consecutive byte-free cycle in ACCUM/DISCARD.
   assign timeout = (state != IDLE) && !bus.i_RX_DV && (tmo_cnt == tmo_last);

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset)
         tmo_cnt <= '0;
      else if (bus.i_RX_DV || state == IDLE || timeout)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + 1'b1;
   end
`else
   localparam int unused_timeout_clks = g_Timeout_Clks;
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state;
      acc_d   = acc;
      cnt_d   = cnt;
      dv_d    = 1'b0;
      err_d   = 1'b0;
      load    = 1'b0;
      if (bus.i_RX_DV) begin
         case (state)
            IDLE: begin
               if (is_digit) begin
                  acc_d   = 10'(digit);
                  cnt_d   = 2'd1;
                  state_d = ACCUM;
               end else if (!is_term) begin
                  err_d   = 1'b1;
                  state_d = DISCARD;
               end
            end
            ACCUM: begin
               if (is_digit) begin
                  if (cnt < 2'd3) begin
                     acc_d = 10'(acc_x10 + 14'(digit));
                     cnt_d = cnt + 2'd1;
                  end else begin
                     err_d   = 1'b1;
                     state_d = DISCARD;
                  end
               end else if (is_term) begin
                  if (acc <= max_angle) begin
                     dv_d = 1'b1;
                     load = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
                  state_d = IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = DISCARD;
               end
            end
            DISCARD: begin
               if (is_term) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (timeout) begin
         err_d   = (state == ACCUM);
         state_d = IDLE;
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state          <= IDLE;
         acc            <= '0;
         cnt            <= '0;
         bus.o_Angle    <= '0;
         bus.o_Angle_DV <= 1'b0;
         bus.o_Error    <= 1'b0;
      end else begin
         state          <= state_d;
         acc            <= acc_d;
         cnt            <= cnt_d;
         bus.o_Angle_DV <= dv_d;
         bus.o_Error    <= err_d;
         if (load) bus.o_Angle <= acc[7:0];
      end
   end
endmodule

// File: doc/angle_cmd_parser.md
ANGLE_CMD_PARSER -- requirements
Module: Angle_Cmd_Parser

Interface
REQ-001 SHALL have parameter g_Max_Angle, default 180: largest accepted angle.
REQ-002 SHALL have parameter g_Timeout_Clks, default 10_000_000: inter-byte timeout, 100 ms at 100 MHz.
REQ-003 SHALL have port i_Clk, input, 1: sole clock, all logic on rising edge.
REQ-004 SHALL have port i_Reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port i_RX_DV, input, 1: one-cycle strobe from UART receiver.
REQ-006 SHALL have port i_RX_Byte, input, 8: received ASCII byte, valid when i_RX_DV=1.
REQ-007 SHALL have port o_Angle_DV, output, 1: one-cycle strobe, new angle valid.
REQ-008 SHALL have port o_Angle, output, 8: last accepted angle, binary 0..g_Max_Angle; feeds the servo control-range stage.
REQ-009 SHALL have port o_Error, output, 1: one-cycle strobe, command rejected.

Function
REQ-010 SHALL parse commands of 1-3 ASCII digits ('0'-'9', 0x30-0x39) terminated by CR (0x0D) or LF (0x0A).
REQ-011 SHALL use states IDLE, ACCUM, DISCARD; bytes are acted on only in cycles with i_RX_DV=1.
REQ-012 IDLE, digit: accumulator = digit, digit count = 1, go to ACCUM.
REQ-013 IDLE, terminator: ignored, stay IDLE, no strobes (so CR+LF yields one command).
REQ-014 IDLE or ACCUM, any other byte: o_Error pulse, go to DISCARD.
REQ-015 ACCUM, digit with count<3: accumulator = accumulator*10 + digit, count+1; accumulator SHALL be 10 bits wide (max 999, no wrap).
REQ-016 ACCUM, digit with count=3: o_Error pulse, go to DISCARD.
REQ-017 ACCUM, terminator, accumulator <= g_Max_Angle: load o_Angle, pulse o_Angle_DV, go IDLE.
REQ-018 ACCUM, terminator, accumulator > g_Max_Angle: o_Error pulse, o_Angle unchanged, go IDLE.
REQ-019 DISCARD: ignore all non-terminator bytes without further o_Error; terminator returns to IDLE silently.
REQ-020 Strobes SHALL be registered: o_Angle_DV/o_Error high exactly one cycle, the cycle after the i_RX_DV cycle carrying the deciding byte; never both high together.
REQ-021 o_Angle SHALL change only together with o_Angle_DV and hold otherwise.
REQ-022 Leading zeros SHALL count as digits ("007" = 7, "0007" = error).

Reset
REQ-023 i_Reset=1 SHALL immediately force IDLE, accumulator 0, count 0, timeout counter 0, o_Angle=0, o_Angle_DV=0, o_Error=0.
REQ-024 Reset mid-command SHALL discard the partial command with no strobe; parsing resumes on the first i_RX_DV after release.

Configuration
REQ-025 With macro ANGLE_CMD_TIMEOUT_EN defined, a counter SHALL clear on every i_RX_DV and, in ACCUM or DISCARD, when it reaches g_Timeout_Clks without a byte, return to IDLE; from ACCUM also pulse o_Error, from DISCARD silently.
REQ-026 Without ANGLE_CMD_TIMEOUT_EN, no timeout counter SHALL be synthesised and ACCUM/DISCARD SHALL persist indefinitely.

Verification
REQ-027 Bytes "9","0",CR -> one o_Angle_DV pulse, o_Angle=90, o_Error stays 0.
REQ-028 Bytes "1","8","1",LF -> o_Error pulse, no o_Angle_DV, o_Angle keeps previous value.
REQ-029 Bytes "4","5",CR,LF then "1","8","0",CR -> exactly two o_Angle_DV pulses, 45 then 180, no o_Error.
REQ-030 Bytes "1","x","2","3",CR then "7",CR -> one o_Error pulse at "x", then o_Angle_DV with o_Angle=7.
REQ-031 Bytes "1","2", i_Reset pulse, then "3",CR -> o_Angle=3, single o_Angle_DV, o_Angle=0 during reset.
REQ-032 ANGLE_CMD_TIMEOUT_EN defined, g_Timeout_Clks=100: "5", idle 100 clocks, "6",CR -> o_Error pulse at timeout, then o_Angle=6.
